// File: rtl/pat_scan_pkg.sv
// pat_scan_pkg
//   Shared types and constants for the pattern-count sequencer.
//   state_t      : sequencer FSM encoding
//   DEF_*        : default address map / memory width
//   CNT_W, IDX_W : counter and byte-index widths
//   PAT_W        : pattern width in bits
package pat_scan_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LDPAT  = 3'd1,
        SCAN   = 3'd2,
        WR_CTB = 3'd3,
        WR_CTO = 3'd4,
        WR_CTS = 3'd5,
        DONE   = 3'd6
    } state_t;

    localparam int DEF_NBYTES   = 32;
    localparam int DEF_PAT_ADDR = 32;
    localparam int DEF_RES_ADDR = 33;
    localparam int DEF_AW       = 8;

    localparam int CNT_W = 8;
    localparam int IDX_W = 6;
    localparam int PAT_W = 5;

endpackage

// File: rtl/pat_window_cnt.sv
// pat_window_cnt
//   Combinational window matcher for one message byte.
//   pat   : 5-bit pattern
//   prev4 : low nibble of the previous byte
//   cur   : current byte
//   first : current byte is byte 0 (no previous byte exists)
//   m     : matches among the four windows wholly inside cur (0..4)
//   x     : matches among the four windows straddling prev4/cur (0..4)
module pat_window_cnt
    import pat_scan_pkg::*;
(
    input  logic [PAT_W-1:0] pat,
    input  logic [3:0]       prev4,
    input  logic [7:0]       cur,
    input  logic             first,
    output logic [2:0]       m,
    output logic [2:0]       x
);

    logic [11:0] w;

    assign w = {prev4, cur};

    // Window k of cur is cur[k+4:k]; crossing window k is w[k+8:k+4],
    // i.e. w[8:4] .. w[11:7], each starting inside prev4.
    always_comb begin
        m = '0;
        x = '0;
        for (int k = 0; k < 4; k++) begin
            if (cur[k +: PAT_W] == pat)
                m = m + 3'd1;
            if (w[(k + 4) +: PAT_W] == pat)
                x = x + 3'd1;
        end
        if (first)
            x = '0;
    end

endmodule

// File: rtl/pat_scan_ctrl.sv
// pat_scan_ctrl
//   Sequencer that loads a 5-bit pattern, scans an NBYTES message and
//   writes three match counts back to data memory.
//   clk       : clock, rising edge
//   reset     : synchronous active-low reset
//   start     : run request, honoured only in IDLE or DONE
//   busy      : block owns the memory port (all states but IDLE/DONE)
//   done      : results written, held until the next start
//   mem_addr  : data-memory address
//   mem_rdata : asynchronous read data for mem_addr
//   mem_we    : write enable
//   mem_wdata : write data
//   Results: RES_ADDR=ctb (total in-byte matches), RES_ADDR+1=cto (bytes
//   with any match), RES_ADDR+2=cts (matches over the whole bit string).
module pat_scan_ctrl
    import pat_scan_pkg::*;
#(
    parameter int NBYTES   = DEF_NBYTES,
    parameter int PAT_ADDR = DEF_PAT_ADDR,
    parameter int RES_ADDR = DEF_RES_ADDR,
    parameter int AW       = DEF_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rdata,
    output logic          mem_we,
    output logic [7:0]    mem_wdata
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [3:0]         prev4;
    logic [PAT_W-1:0]   pat;
    logic [CNT_W-1:0]   ctb, cto, cts;
    logic [2:0]         m, x;

    pat_window_cnt u_win (
        .pat   (pat),
        .prev4 (prev4),
        .cur   (mem_rdata),
        .first (idx == '0),
        .m     (m),
        .x     (x)
    );

    // Next state and memory-port drive are pure decodes of state, so a
    // reset edge forces the port quiet in the very next cycle.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = LDPAT;
            end
            LDPAT: begin
                busy      = 1'b1;
                mem_addr  = AW'(PAT_ADDR);
                state_nxt = SCAN;
            end
            SCAN: begin
                busy     = 1'b1;
                mem_addr = AW'(idx);
                if (idx == LAST_IDX)
                    state_nxt = WR_CTB;
            end
            WR_CTB: begin
                busy      = 1'b1;
                mem_addr  = AW'(RES_ADDR);
                mem_we    = 1'b1;
                mem_wdata = ctb;
                state_nxt = WR_CTO;
            end
            WR_CTO: begin
                busy      = 1'b1;
                mem_addr  = AW'(RES_ADDR + 1);
                mem_we    = 1'b1;
                mem_wdata = cto;
                state_nxt = WR_CTS;
            end
            WR_CTS: begin
                busy      = 1'b1;
                mem_addr  = AW'(RES_ADDR + 2);
                mem_we    = 1'b1;
                mem_wdata = cts;
                state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start)
                    state_nxt = LDPAT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            idx   <= '0;
            prev4 <= '0;
            pat   <= '0;
            ctb   <= '0;
            cto   <= '0;
            cts   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        idx   <= '0;
                        prev4 <= '0;
                        ctb   <= '0;
                        cto   <= '0;
                        cts   <= '0;
                    end
                end
                LDPAT: begin
                    pat <= mem_rdata[7:3];
                end
                SCAN: begin
                    ctb   <= ctb + CNT_W'(m);
                    cto   <= cto + CNT_W'(m != 3'd0);
                    cts   <= cts + CNT_W'(m) + CNT_W'(x);
                    prev4 <= mem_rdata[3:0];
                    idx   <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pat_scan_ctrl.sv
// tb_pat_scan_ctrl
//   Directed bench for pat_scan_ctrl with a behavioural data memory.
//   The message image is described by fill/b0/b1 and the pattern byte;
//   the result locations are a separate register file written only by
//   the DUT write port (res_clr presets them to 0xAA).
module tb_pat_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       busy, done;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata;
    logic       mem_we;
    logic [7:0] mem_wdata;

    logic [7:0] fill, b0, b1, pat_byte;
    logic [7:0] res [3];
    logic       res_clr;
    int         wr_cnt, bad_wr;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    pat_scan_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata)
    );

    always_comb begin
        mem_rdata = 8'h00;
        case (mem_addr)
            8'd0:    mem_rdata = b0;
            8'd1:    mem_rdata = b1;
            8'd32:   mem_rdata = pat_byte;
            8'd33:   mem_rdata = res[0];
            8'd34:   mem_rdata = res[1];
            8'd35:   mem_rdata = res[2];
            default: if (mem_addr < 8'd32) mem_rdata = fill;
        endcase
    end

    always @(posedge clk) begin
        if (res_clr) begin
            res[0] <= 8'hAA;
            res[1] <= 8'hAA;
            res[2] <= 8'hAA;
            wr_cnt <= 0;
            bad_wr <= 0;
        end else if (mem_we) begin
            wr_cnt <= wr_cnt + 1;
            case (mem_addr)
                8'd33:   res[0] <= mem_wdata;
                8'd34:   res[1] <= mem_wdata;
                8'd35:   res[2] <= mem_wdata;
                default: bad_wr <= bad_wr + 1;
            endcase
        end
    end

    // Standalone matcher for direct window checks.
    logic [4:0] tpat;
    logic [3:0] tprev;
    logic [7:0] tcur;
    logic       tfirst;
    logic [2:0] tm, tx;

    pat_window_cnt u_win_chk (
        .pat   (tpat),
        .prev4 (tprev),
        .cur   (tcur),
        .first (tfirst),
        .m     (tm),
        .x     (tx)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_results();
        res_clr = 1'b1;
        tick();
        res_clr = 1'b0;
    endtask

    // Start at edge E, optionally pulse start again mid-scan, and check
    // done rises exactly at E+36 with the three expected result bytes.
    task automatic run_check(input string tag, input logic [7:0] e_ctb,
                             input logic [7:0] e_cto, input logic [7:0] e_cts,
                             input bit pulse_mid);
        clear_results();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_ldpat_busy"}, busy, 1);
        chk({tag, "_ldpat_addr"}, mem_addr, 32);
        for (int i = 1; i <= 35; i++) begin
            if (pulse_mid && i == 10) start = 1'b1;
            tick();
            start = 1'b0;
        end
        chk({tag, "_done_e35"}, done, 0);
        chk({tag, "_busy_e35"}, busy, 1);
        tick();
        chk({tag, "_done_e36"}, done, 1);
        chk({tag, "_busy_e36"}, busy, 0);
        chk({tag, "_ctb"}, res[0], e_ctb);
        chk({tag, "_cto"}, res[1], e_cto);
        chk({tag, "_cts"}, res[2], e_cts);
        chk({tag, "_wr_cnt"}, wr_cnt, 3);
        chk({tag, "_bad_wr"}, bad_wr, 0);
    endtask

    initial begin
        bit saw_we, saw_done;
        reset    = 1'b0;
        start    = 1'b0;
        res_clr  = 1'b1;
        fill     = 8'h00;
        b0       = 8'h00;
        b1       = 8'h00;
        pat_byte = 8'h00;

        // Window matcher, hand-computed vectors.
        tpat = 5'b10101; tprev = 4'b0101; tcur = 8'h55; tfirst = 1'b0; #1;
        chk("win_55_m", tm, 2);
        chk("win_55_x", tx, 2);
        tfirst = 1'b1; #1;
        chk("win_55_first_x", tx, 0);
        tpat = 5'b11111; tprev = 4'b0011; tcur = 8'hE0; tfirst = 1'b0; #1;
        chk("win_cross_m", tm, 0);
        chk("win_cross_x", tx, 1);
        tpat = 5'b00000; tprev = 4'b0000; tcur = 8'h00; #1;
        chk("win_zero_m", tm, 4);
        chk("win_zero_x", tx, 4);

        // Reset state.
        tick();
        tick();
        res_clr = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);

        // Reset beats start at the same edge.
        start = 1'b1;
        tick();
        chk("rst_vs_start_busy", busy, 0);
        reset = 1'b1;
        start = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        // pat=00000, all zero message.
        run_check("zero", 8'd128, 8'd32, 8'd252, 1'b0);

        // pat=10101, all 0x55, with a start pulse mid-scan that must be ignored.
        fill = 8'h55; b0 = 8'h55; b1 = 8'h55; pat_byte = 8'hA8;
        run_check("alt55", 8'd64, 8'd32, 8'd126, 1'b1);

        // pat=11111, all 0xFF.
        fill = 8'hFF; b0 = 8'hFF; b1 = 8'hFF; pat_byte = 8'hF8;
        run_check("ones", 8'd128, 8'd32, 8'd252, 1'b0);

        // Crossing-only match between byte 0 and byte 1.
        fill = 8'h00; b0 = 8'h03; b1 = 8'hE0; pat_byte = 8'hF8;
        run_check("cross", 8'd0, 8'd0, 8'd1, 1'b0);

        // Abort with reset at SCAN idx=10.
        clear_results();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (11) tick();
        chk("abort_scan_idx", mem_addr, 10);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_we", mem_we, 0);
        chk("abort_addr", mem_addr, 0);
        chk("abort_wdata", mem_wdata, 0);
        saw_we = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (mem_we) saw_we = 1'b1;
            if (done) saw_done = 1'b1;
        end
        chk("abort_no_we", saw_we, 0);
        chk("abort_no_done", saw_done, 0);
        chk("abort_wr_cnt", wr_cnt, 0);
        chk("abort_res_kept", res[2], 8'hAA);

        // Fresh run after the abort.
        run_check("restart", 8'd0, 8'd0, 8'd1, 1'b0);

        // done holds through 20 idle cycles.
        repeat (20) tick();
        chk("done_hold", done, 1);
        chk("done_hold_busy", busy, 0);

        // Restart from DONE with a new message; results get rewritten.
        fill = 8'h00; b0 = 8'h00; b1 = 8'h00; pat_byte = 8'h00;
        run_check("rerun", 8'd128, 8'd32, 8'd252, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
